// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin / fixed-priority lock arbiter.
//   arb_mode_e    : arbitration policy selected at each pick
//   arb_state_e   : controller state (IDLE, GRANT)
//   onehot_to_idx : index of the set bit in a one-hot vector (0 for all-zero)
package arb_pkg;

  typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_e;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_e;

  localparam int MAX_N = 16;

  // OR-reduction of set-bit indices; exact for one-hot or zero inputs.
  function automatic int onehot_to_idx(input logic [MAX_N-1:0] vec);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (vec[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection.
//   eligible : candidate requesters
//   base     : round-robin start index (ignored in fixed mode)
//   mask     : candidates with a cleared bit are skipped
//   mode     : ARB_FIXED = lowest index, ARB_RR = first at/after base, wrapping
//   winner   : chosen index (0 when none found)
//   found    : a winner exists
module arb_pick
  import arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   eligible,
  input  logic [IDW-1:0] base,
  input  logic [N-1:0]   mask,
  input  arb_mode_e      mode,
  output logic [IDW-1:0] winner,
  output logic           found
);

  logic [N-1:0]   cand;
  logic [IDW-1:0] pos;

  always_comb begin
    cand   = eligible & mask;
    winner = '0;
    found  = 1'b0;
    pos    = '0;
    for (int k = 0; k < N; k++) begin
      if (mode == ARB_RR) pos = IDW'((int'(base) + k) % N);
      else                pos = IDW'(k);
      if (!found && cand[pos]) begin
        found  = 1'b1;
        winner = pos;
      end
    end
  end

endmodule

// File: rtl/rr_lock_arbiter.sv
// N-requester arbiter with fixed-priority / round-robin modes, per-requester
// enables and grant locking bounded by a hold quota.
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   req, en     : request and enable per requester; eligible = req & en
//   mode        : 0 fixed priority, 1 round-robin (sampled only at a pick)
//   grant       : registered one-hot grant
//   grant_id    : index of the granted requester, 0 when idle
//   grant_valid : high iff grant != 0
//
// state | meaning
// IDLE  | no grant outstanding
// GRANT | one requester holds the grant; hold_cnt counts its cycles
module rr_lock_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4,
  localparam int IDW     = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   en,
  input  logic           mode,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           grant_valid
);

  localparam int HCW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

  arb_state_e     state, state_n;
  logic [N-1:0]   grant_n, eligible, pick_mask;
  logic [IDW-1:0] rr_ptr, rr_ptr_n, holder, winner, ptr_src;
  logic [HCW-1:0] hold_cnt, hold_cnt_n;
  logic           found, holder_elig, quota_hit, take, retain;

  // X on req/en must not produce an eligible requester.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N; i++) begin
      eligible[i] = (req[i] === 1'b1) && (en[i] === 1'b1);
    end
  end

  assign holder      = IDW'(onehot_to_idx(MAX_N'(grant)));
  assign holder_elig = eligible[holder];
  assign quota_hit   = (MAX_HOLD != 0) && (int'(hold_cnt) == MAX_HOLD);

  // On quota expiry the current holder is excluded so another requester wins.
  assign pick_mask = (state == GRANT && holder_elig && quota_hit) ? ~grant : '1;

  arb_pick #(.N(N)) u_pick (
    .eligible (eligible),
    .base     (rr_ptr),
    .mask     (pick_mask),
    .mode     (arb_mode_e'(mode)),
    .winner   (winner),
    .found    (found)
  );

  always_comb begin
    state_n    = state;
    grant_n    = grant;
    hold_cnt_n = hold_cnt;
    rr_ptr_n   = rr_ptr;
    take       = 1'b0;
    retain     = 1'b0;
    ptr_src    = winner;

    case (state)
      IDLE: begin
        if (found) take = 1'b1;
      end
      GRANT: begin
        if (!holder_elig) begin
          if (found) begin
            take = 1'b1;
          end else begin
            state_n    = IDLE;
            grant_n    = '0;
            hold_cnt_n = '0;
          end
        end else if (!quota_hit) begin
          if (hold_cnt != '1) hold_cnt_n = hold_cnt + 1'b1;
        end else if (found) begin
          take = 1'b1;
        end else begin
          retain = 1'b1;
        end
      end
      default: begin
        state_n    = IDLE;
        grant_n    = '0;
        hold_cnt_n = '0;
      end
    endcase

    if (take) begin
      state_n    = GRANT;
      grant_n    = N'(1) << winner;
      hold_cnt_n = HCW'(1);
    end
    if (retain) begin
      hold_cnt_n = HCW'(1);
      ptr_src    = holder;
    end
    // A fresh grant (or a retain after quota) moves the pointer past the winner.
    if (take || retain) begin
      rr_ptr_n = (int'(ptr_src) == N - 1) ? '0 : ptr_src + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      hold_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      hold_cnt <= hold_cnt_n;
      rr_ptr   <= rr_ptr_n;
    end
  end

  assign grant_id    = holder;
  assign grant_valid = |grant;

  property p_known_inputs;
    @(posedge clk) !reset |-> !$isunknown({req, en});
  endproperty
  a_known_inputs: assert property (p_known_inputs);

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Randomised and directed stimulus for rr_lock_arbiter, checked by a
// scoreboard fed from a behavioural model of the arbitration rules.
module tb_rr_lock_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int IDW      = $clog2(N);

  logic           clk;
  logic           reset;
  logic [N-1:0]   req, en;
  logic           mode;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           grant_valid;

  rr_lock_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .en          (en),
    .mode        (mode),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   grant;
    logic [IDW-1:0] id;
    logic           valid;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: holder (-1 = none), cycles held, round-robin start.
  int m_hold = -1;
  int m_cnt  = 0;
  int m_ptr  = 0;

  function automatic int model_pick(input bit el[N], input int excl, input bit rr);
    int order[$];
    for (int k = 0; k < N; k++) order.push_back(rr ? (m_ptr + k) % N : k);
    foreach (order[j]) begin
      if (el[order[j]] && order[j] != excl) return order[j];
    end
    return -1;
  endfunction

  task automatic model_step(input bit rst, input logic [N-1:0] r,
                            input logic [N-1:0] e, input bit md);
    bit el[N];
    int w;
    if (rst) begin
      m_hold = -1; m_cnt = 0; m_ptr = 0;
      return;
    end
    for (int i = 0; i < N; i++) el[i] = 1'(((r & e) >> i));
    if (m_hold < 0 || !el[m_hold]) begin
      w = model_pick(el, -1, md);
      if (w >= 0) begin
        m_hold = w; m_cnt = 1; m_ptr = (w + 1) % N;
      end else begin
        m_hold = -1; m_cnt = 0;
      end
    end else if (MAX_HOLD == 0 || m_cnt < MAX_HOLD) begin
      m_cnt = m_cnt + 1;
    end else begin
      w = model_pick(el, m_hold, md);
      if (w >= 0) m_hold = w;
      m_cnt = 1;
      m_ptr = (m_hold + 1) % N;
    end
  endtask

  task automatic apply(input bit rst, input logic [N-1:0] r,
                       input logic [N-1:0] e, input bit md);
    exp_t x;
    @(negedge clk);
    reset = rst; req = r; en = e; mode = md;
    model_step(rst, r, e, md);
    x.grant = (m_hold >= 0) ? N'(1 << m_hold) : '0;
    x.id    = (m_hold >= 0) ? IDW'(m_hold) : '0;
    x.valid = (m_hold >= 0);
    exp_q.push_back(x);
  endtask

  // Monitor: compares just after each rising edge against the oldest expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checks++;
        if (grant !== x.grant || grant_id !== x.id || grant_valid !== x.valid) begin
          errors++;
          $display("FAIL grant_check t=%0t: got grant=%b id=%0d valid=%b, expected grant=%b id=%0d valid=%b",
                   $time, grant, grant_id, grant_valid, x.grant, x.id, x.valid);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] r, e;
    bit           md, rst;
    int           guard;

    reset = 1'b1; req = '0; en = '0; mode = 1'b0;

    // Reset held with all requesting, then round-robin quota rotation.
    apply(1, 4'hF, 4'hF, 1);
    apply(1, 4'hF, 4'hF, 1);
    repeat (20) apply(0, 4'hF, 4'hF, 1);

    // Fixed priority, late lower-index request, then drop with no bubble.
    apply(1, 4'h0, 4'hF, 0);
    repeat (2) apply(0, 4'b1010, 4'hF, 0);
    repeat (5) apply(0, 4'b1011, 4'hF, 0);
    repeat (3) apply(0, 4'b1010, 4'hF, 0);

    // Enable mask skips requester 2; then disable whoever holds.
    apply(1, 4'h0, 4'hF, 1);
    repeat (10) apply(0, 4'hF, 4'b1011, 1);
    apply(0, 4'hF, 4'b1011 & ~N'(1 << (m_hold < 0 ? 0 : m_hold)), 1);
    repeat (2) apply(0, 4'hF, 4'b1011, 1);

    // Sole requester retains through quota; pointer ends past it.
    apply(1, 4'h0, 4'hF, 1);
    repeat (10) apply(0, 4'b0100, 4'b0100, 1);
    repeat (3) apply(0, 4'hF, 4'hF, 1);

    // Reset while requester 3 holds.
    guard = 0;
    while (m_hold != 3 && guard < 20) begin
      apply(0, 4'hF, 4'hF, 1);
      guard++;
    end
    checks++;
    if (m_hold != 3) begin
      errors++;
      $display("FAIL reach_holder3: got holder=%0d, expected 3", m_hold);
    end
    apply(1, 4'hF, 4'hF, 1);
    repeat (3) apply(0, 4'hF, 4'hF, 1);

    // Randomised: mostly sticky requests so quotas expire, occasional resets.
    r = 4'hF; e = 4'hF; md = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) r = N'($urandom | $urandom);
      if ($urandom_range(0, 11) == 0) e = ($urandom_range(0, 2) == 0) ? N'($urandom) : 4'hF;
      if ($urandom_range(0, 19) == 0) md = ~md;
      rst = ($urandom_range(0, 59) == 0);
      apply(rst, r, e, md);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
